// File: rtl/btn_sw_conditioner.sv
// rtl/btn_sw_conditioner.sv - debounces one push-button and a slide-switch bus
// Both paths qualify synchronized inputs over STABLE_CYCLES, then present results through an output register stage.
module btn_sw_conditioner #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int SW_WIDTH      = 7
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                btn_in,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic                btn_pulse,
  output logic                btn_level,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                sw_changed
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} bstate_t;

  logic                btn_m, btn_s;
  logic [SW_WIDTH-1:0] sw_m, sw_s;

  bstate_t             state;
  logic [CW-1:0]       bcnt;
  logic                press_hit;
  logic                lvl;

  logic [SW_WIDTH-1:0] cand;
  logic [SW_WIDTH-1:0] acc;
  logic                acc_chg;
  logic [CW-1:0]       scnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn_in;
      btn_s <= btn_m;
      sw_m  <= sw_in;
      sw_s  <= sw_m;
    end
  end

  // press_hit/lvl are the qualified results; the ports re-register them one cycle later
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      bcnt      <= '0;
      press_hit <= 1'b0;
      lvl       <= 1'b0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      btn_pulse <= press_hit;
      btn_level <= lvl;
      press_hit <= 1'b0;
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (btn_s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            bcnt  <= '0;
          end else if (bcnt == LAST) begin
            state     <= HELD;
            bcnt      <= '0;
            press_hit <= 1'b1;
            lvl       <= 1'b1;
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        HELD: begin
          bcnt <= '0;
          lvl  <= 1'b1;
          if (!btn_s) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            bcnt  <= '0;
          end else if (bcnt == LAST) begin
            state <= IDLE;
            bcnt  <= '0;
            lvl   <= 1'b0;
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

  // One shared window: any bit moving restarts qualification for the whole vector
  always_ff @(posedge clk) begin
    if (clr) begin
      cand       <= '0;
      acc        <= '0;
      acc_chg    <= 1'b0;
      scnt       <= '0;
      sw_out     <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_out     <= acc;
      sw_changed <= acc_chg;
      acc_chg    <= 1'b0;
      if (sw_s != cand) begin
        cand <= sw_s;
        scnt <= '0;
      end else if (cand != acc && scnt == LAST) begin
        acc     <= cand;
        acc_chg <= 1'b1;
        scnt    <= '0;
      end else if (cand != acc) begin
        scnt <= scnt + ONE;
      end else begin
        scnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// tb/tb_btn_sw_conditioner.sv - randomized and directed bench for btn_sw_conditioner
// Reference: an input is accepted once its last S+1 synchronized samples agree; outputs show it one edge later.
module tb_btn_sw_conditioner;

  localparam int S = 4;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         clr;
  logic         btn_in;
  logic [W-1:0] sw_in;
  logic         btn_pulse;
  logic         btn_level;
  logic [W-1:0] sw_out;
  logic         sw_changed;

  int checks = 0;
  int errors = 0;

  bit           bq[$];
  logic [W-1:0] sq[$];
  bit           d_b;
  bit           ip;
  logic [W-1:0] acc;
  bit           chg;
  logic [9:0]   exp_vec;

  always #5 clk = ~clk;

  btn_sw_conditioner #(.STABLE_CYCLES(S), .SW_WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_in     (btn_in),
    .sw_in      (sw_in),
    .btn_pulse  (btn_pulse),
    .btn_level  (btn_level),
    .sw_out     (sw_out),
    .sw_changed (sw_changed)
  );

  // Queues hold raw samples; the newest two are still inside the synchronizer
  task automatic step();
    bit all_eq;
    bit same;
    @(posedge clk);
    if (clr) begin
      bq.delete();
      sq.delete();
      for (int i = 0; i < S + 3; i++) begin
        bq.push_back(1'b0);
        sq.push_back('0);
      end
      d_b = 1'b0; ip = 1'b0; acc = '0; chg = 1'b0;
      exp_vec = '0;
    end else begin
      bq.push_back(btn_in);
      void'(bq.pop_front());
      sq.push_back(sw_in);
      void'(sq.pop_front());
      exp_vec = {ip, d_b, chg, acc};
      all_eq = 1'b1;
      for (int i = 0; i <= S; i++) if (bq[i] == d_b) all_eq = 1'b0;
      ip = all_eq && !d_b;
      if (all_eq) d_b = !d_b;
      same = 1'b1;
      for (int i = 0; i <= S; i++) if (sq[i] != sq[0]) same = 1'b0;
      chg = same && (sq[0] != acc);
      if (chg) acc = sq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; btn_in = 1'b1; sw_in = 7'h7F;
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if ({btn_pulse, btn_level, sw_changed, sw_out} !== 10'h000) begin
        errors++;
        $display("FAIL reset n=%0d got %h want 000", n, {btn_pulse, btn_level, sw_changed, sw_out});
      end
    end
    btn_in = 1'b0; sw_in = '0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_press();
    int pulses = 0;
    int pedge = -1;
    for (int n = 0; n < 3; n++) step();
    btn_in = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if ({btn_pulse, btn_level, sw_changed, sw_out} !== exp_vec) begin
        errors++;
        $display("FAIL press_model n=%0d got %h want %h", n, {btn_pulse, btn_level, sw_changed, sw_out}, exp_vec);
      end
      if (btn_pulse) begin pulses++; pedge = n; end
    end
    checks++;
    if (pulses != 1 || pedge != S + 3 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL press_latency got pulses=%0d edge=%0d level=%b want 1/%0d/1", pulses, pedge, btn_level, S + 3);
    end
  endtask

  task automatic test_release();
    int pulses = 0;
    int rel_edge = -1;
    btn_in = 1'b0; step(); step();
    btn_in = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if ({btn_pulse, btn_level} !== 2'b01 || {btn_pulse, btn_level, sw_changed, sw_out} !== exp_vec) begin
        errors++;
        $display("FAIL release_glitch n=%0d got %h want %h", n, {btn_pulse, btn_level, sw_changed, sw_out}, exp_vec);
      end
    end
    btn_in = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (btn_pulse) pulses++;
      if (!btn_level && rel_edge < 0) rel_edge = n;
    end
    checks++;
    if (rel_edge != S + 3 || pulses != 0) begin
      errors++;
      $display("FAIL release_latency got edge=%0d pulses=%0d want %0d/0", rel_edge, pulses, S + 3);
    end
  endtask

  task automatic test_bounce();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 16; n++) begin
      btn_in = (n < 4) ? pat[n] : 1'b0;
      step();
      checks++;
      if ({btn_pulse, btn_level} !== 2'b00 || {btn_pulse, btn_level, sw_changed, sw_out} !== exp_vec) begin
        errors++;
        $display("FAIL bounce n=%0d got %h want %h", n, {btn_pulse, btn_level, sw_changed, sw_out}, exp_vec);
      end
    end
  endtask

  task automatic test_switch();
    int strobes = 0;
    int sedge = -1;
    sw_in = 7'h15;
    for (int n = 0; n < 12; n++) begin
      step();
      if (sw_changed) begin strobes++; sedge = n; end
    end
    checks++;
    if (strobes != 1 || sedge != S + 3 || sw_out !== 7'h15) begin
      errors++;
      $display("FAIL switch_accept got strobes=%0d edge=%0d out=%h want 1/%0d/15", strobes, sedge, sw_out, S + 3);
    end
    sw_in = 7'h14; step();
    sw_in = 7'h15;
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if (sw_changed !== 1'b0 || sw_out !== 7'h15) begin
        errors++;
        $display("FAIL switch_glitch n=%0d got chg=%b out=%h want 0/15", n, sw_changed, sw_out);
      end
    end
  endtask

  task automatic test_clr_midpress();
    int pedge = -1;
    btn_in = 1'b1;
    for (int n = 0; n < 5; n++) step();
    clr = 1'b1;
    step();
    checks++;
    if ({btn_pulse, btn_level, sw_changed, sw_out} !== 10'h000) begin
      errors++;
      $display("FAIL clr_midpress got %h want 000", {btn_pulse, btn_level, sw_changed, sw_out});
    end
    clr = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if ({btn_pulse, btn_level, sw_changed, sw_out} !== exp_vec) begin
        errors++;
        $display("FAIL requalify n=%0d got %h want %h", n, {btn_pulse, btn_level, sw_changed, sw_out}, exp_vec);
      end
      if (btn_pulse) pedge = n;
    end
    checks++;
    if (pedge != S + 3) begin
      errors++;
      $display("FAIL requalify_edge got %0d want %0d", pedge, S + 3);
    end
  endtask

  task automatic test_simultaneous();
    int pedge = -1;
    int sedge = -1;
    btn_in = 1'b0; sw_in = '0;
    for (int n = 0; n < 14; n++) step();
    btn_in = 1'b1; sw_in = 7'h7F;
    for (int n = 0; n < 12; n++) begin
      step();
      if (btn_pulse) pedge = n;
      if (sw_changed) sedge = n;
    end
    checks++;
    if (pedge != S + 3 || sedge != S + 3 || sw_out !== 7'h7F) begin
      errors++;
      $display("FAIL simultaneous got pulse@%0d chg@%0d out=%h want %0d/%0d/7f", pedge, sedge, sw_out, S + 3, S + 3);
    end
  endtask

  task automatic test_random();
    int hold_b = 0;
    int hold_s = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold_b == 0) begin
        btn_in = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 9);
      end
      if (hold_s == 0) begin
        sw_in = ($urandom_range(0, 3) == 0) ? sw_in ^ (7'h1 << $urandom_range(0, 6)) : 7'($urandom_range(0, 127));
        hold_s = $urandom_range(1, 9);
      end
      hold_b--; hold_s--;
      clr = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if ({btn_pulse, btn_level, sw_changed, sw_out} !== exp_vec) begin
        errors++;
        $display("FAIL random n=%0d got %h want %h", n, {btn_pulse, btn_level, sw_changed, sw_out}, exp_vec);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; btn_in = 1'b0; sw_in = '0;
    exp_vec = '0; d_b = 1'b0; ip = 1'b0; acc = '0; chg = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_switch();
    test_clr_midpress();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_sw_conditioner.md
BTN_SW_CONDITIONER -- requirements
Module: btn_sw_conditioner

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000000, is the number of consecutive clk cycles an input must hold one value before it is accepted (10 ms at 100 MHz); legal values are >= 2.
REQ-002 Parameter SW_WIDTH, default 7, is the width of the switch bus.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 btn_in  input  1  raw asynchronous push-button level; 1 means pressed.
REQ-006 sw_in  input  SW_WIDTH  raw asynchronous slide-switch levels.
REQ-007 btn_pulse  output  1  single-cycle strobe on each debounced press.
REQ-008 btn_level  output  1  debounced button level.
REQ-009 sw_out  output  SW_WIDTH  debounced switch vector.
REQ-010 sw_changed  output  1  single-cycle strobe whenever sw_out updates.
REQ-011 All outputs shall be registered.

Function
REQ-012 btn_in and each sw_in bit shall pass through a two-flop synchronizer; only the second-stage values (btn_s, sw_s) are used downstream.
REQ-013 The button FSM shall have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with a counter bcnt of ceil(log2(STABLE_CYCLES)) bits.
REQ-014 IDLE: if btn_s=1, go to PRESS_WAIT with bcnt=0; otherwise stay.
REQ-015 PRESS_WAIT: if btn_s=0, return to IDLE with bcnt=0; if btn_s=1 and bcnt=STABLE_CYCLES-1, go to HELD and assert btn_pulse and btn_level; otherwise increment bcnt.
REQ-016 HELD: if btn_s=0, go to RELEASE_WAIT with bcnt=0; otherwise stay, with btn_level=1.
REQ-017 RELEASE_WAIT: if btn_s=1, return to HELD with bcnt=0; if btn_s=0 and bcnt=STABLE_CYCLES-1, go to IDLE and clear btn_level; otherwise increment bcnt.
REQ-018 btn_pulse shall be high for exactly one cycle per IDLE-to-HELD acceptance and never on release.
REQ-019 Press latency: take the first edge that samples btn_in=1 as edge 0, with btn_in held high thereafter; btn_pulse and btn_level shall be registered high at edge STABLE_CYCLES+3.
REQ-020 A bounce, meaning any btn_s change before bcnt reaches STABLE_CYCLES-1, shall restart qualification and produce no pulse.
REQ-021 The switch path shall hold a candidate register cand[SW_WIDTH] and a counter scnt.
REQ-022 Switch path, each edge, in priority order:
- if sw_s != cand: cand<=sw_s, scnt<=0;
- else if cand != sw_out and scnt = STABLE_CYCLES-1: sw_out<=cand, sw_changed<=1, scnt<=0;
- else if cand != sw_out: scnt++;
- else: scnt<=0.
REQ-023 A change on any switch bit restarts the shared switch qualification window for the whole vector.
REQ-024 Multiple switch bits settling inside one window shall update sw_out in a single step with one sw_changed strobe.
REQ-025 The button path and the switch path shall be independent; simultaneous events on both are each processed in the same cycle.
REQ-026 bcnt and scnt shall never exceed STABLE_CYCLES-1 and shall not wrap.

Reset
REQ-027 While clr=1 at an edge, the following shall be cleared to 0: synchronizer flops, cand, sw_out, bcnt, scnt, btn_pulse, btn_level and sw_changed; FSM=IDLE.
REQ-028 clr shall take priority over all other activity, including a pending btn_pulse or sw_changed.
REQ-029 Switches already on when reset is released shall be accepted through the normal REQ-022 path, producing one sw_changed strobe.
REQ-030 A button held through the release of reset shall be qualified as a fresh press from IDLE.

Verification (STABLE_CYCLES=4)
REQ-031 clr for 2 cycles, then btn_in=1 held -> btn_pulse high for exactly one cycle at edge 7 after the first sample, then btn_level=1 and stays 1.
REQ-032 btn_in toggles 1,0,1,0 on successive cycles, then stays 0 -> no btn_pulse, btn_level stays 0, FSM returns to IDLE.
REQ-033 Button held (HELD), btn_in=0 for 2 cycles then 1 -> btn_level stays 1 and no new btn_pulse; a later sustained 0 clears btn_level 7 edges after the first 0 sample.
REQ-034 sw_in 0x00 -> 0x15 held -> sw_out=0x15 and one sw_changed strobe 7 edges after the change; sw_in 0x15 -> 0x14 -> 0x15 within 2 cycles -> sw_out unchanged, no strobe.
REQ-035 clr asserted during PRESS_WAIT with bcnt=2 -> all outputs 0 next cycle; a continued press is then requalified in full from IDLE.
REQ-036 btn_in and sw_in (0x7F) change on the same cycle -> btn_pulse and sw_changed asserted in the same cycle.
